// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered N-to-2^N one-hot decoder with direct hold and timed scan modes
module decoder_scan #(
  parameter int N          = 3,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic            load,
  input  logic [N-1:0]    i,
  output logic [2**N-1:0] q,
  output logic [N-1:0]    idx,
  output logic            active,
  output logic            wrap
);

  localparam int            W      = 2**N;
  localparam logic [7:0]    LAST   = 8'(DWELL - 1);
  localparam logic [W-1:0]  IDLE_Q = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};
  localparam logic [W-1:0]  ONE    = W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           wrap_q, wrap_d;
  logic           active_q, active_d;
  logic [W-1:0]   q_q, q_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mode) begin
            state_d = SCAN;
            idx_d   = i;
            cnt_d   = 8'd0;
          end else if (load) begin
            state_d = HOLD;
            idx_d   = i;
          end
        end
        HOLD: begin
          // Entering scan from hold continues from the held line, not from i.
          if (mode) begin
            state_d = SCAN;
            cnt_d   = 8'd0;
          end else if (load) begin
            idx_d = i;
          end
        end
        SCAN: begin
          if (!mode) begin
            state_d = HOLD;
            cnt_d   = 8'd0;
          end else if (load) begin
            idx_d = i;
            cnt_d = 8'd0;
          end else if (cnt_q == LAST) begin
            cnt_d  = 8'd0;
            idx_d  = idx_q + 1'b1;
            wrap_d = (idx_q == {N{1'b1}});
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end

    active_d = (state_d != IDLE);
    // q is decoded from the next index so it lines up with idx in the same cycle.
    if (state_d == IDLE) begin
      q_d = IDLE_Q;
    end else begin
      q_d = (ONE << idx_d) ^ IDLE_Q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= 8'd0;
      wrap_q   <= 1'b0;
      active_q <= 1'b0;
      q_q      <= IDLE_Q;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      active_q <= active_d;
      q_q      <= q_d;
    end
  end

  assign q      = q_q;
  assign idx    = idx_q;
  assign active = active_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - randomized and directed check of decoder_scan against a behavioural model
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [2:0] i = 3'd0;

  logic [7:0] qa, qb;
  logic [2:0] idxa, idxb;
  logic       acta, actb, wrapa, wrapb;

  decoder_scan #(.N(3), .DWELL(4), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .i(i),
    .q(qa), .idx(idxa), .active(acta), .wrap(wrapa)
  );

  decoder_scan #(.N(3), .DWELL(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .i(i),
    .q(qb), .idx(idxb), .active(actb), .wrap(wrapb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Model: mode 0 = idle, 1 = holding, 2 = scanning.
  int       m_st[2];
  int       m_idx[2];
  int       m_cnt[2];
  bit       m_wrap[2];
  int       dw_of[2] = '{4, 1};
  bit [7:0] pol[2] = '{8'h00, 8'hFF};

  logic [7:0] dq[2];
  logic [2:0] didx[2];
  logic       dact[2];
  logic       dwrap[2];
  assign dq[0] = qa;      assign dq[1] = qb;
  assign didx[0] = idxa;  assign didx[1] = idxb;
  assign dact[0] = acta;  assign dact[1] = actb;
  assign dwrap[0] = wrapa; assign dwrap[1] = wrapb;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void step(input int st, input int ix, input int cnt, input int dw,
                               input bit e, input bit m, input bit l, input int iv,
                               output int nst, output int nix, output int ncnt, output bit nw);
    nst = st; nix = ix; ncnt = cnt; nw = 1'b0;
    if (!e) begin
      nst = 0;
    end else if (st == 0) begin
      if (m) begin nst = 2; nix = iv; ncnt = 0; end
      else if (l) begin nst = 1; nix = iv; end
    end else if (st == 1) begin
      if (m) begin nst = 2; ncnt = 0; end
      else if (l) nix = iv;
    end else begin
      if (!m) nst = 1;
      else if (l) begin nix = iv; ncnt = 0; end
      else if (cnt + 1 == dw) begin
        ncnt = 0;
        nix  = (ix + 1) % 8;
        nw   = (ix == 7);
      end else ncnt = cnt + 1;
    end
  endfunction

  int ns, ni, nc;
  bit nw;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 2; j++) begin
        m_st[j] <= 0; m_idx[j] <= 0; m_cnt[j] <= 0; m_wrap[j] <= 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        step(m_st[j], m_idx[j], m_cnt[j], dw_of[j], en, mode, load, int'(i), ns, ni, nc, nw);
        m_st[j] <= ns; m_idx[j] <= ni; m_cnt[j] <= nc; m_wrap[j] <= nw;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int j = 0; j < 2; j++) begin
        logic [7:0] eq;
        eq = (m_st[j] == 0) ? pol[j] : ((8'h01 << m_idx[j]) ^ pol[j]);
        chk($sformatf("q[%0d]", j), dq[j], int'(eq));
        chk($sformatf("idx[%0d]", j), didx[j], m_idx[j]);
        chk($sformatf("active[%0d]", j), dact[j], (m_st[j] != 0) ? 1 : 0);
        chk($sformatf("wrap[%0d]", j), dwrap[j], m_wrap[j] ? 1 : 0);
        chk($sformatf("onehot[%0d]", j), $countones(dq[j] ^ pol[j]), dact[j] ? 1 : 0);
        chk($sformatf("wrap_outside_scan[%0d]", j), dwrap[j] & ~dact[j], 0);
      end
    end
  end

  initial begin
    int wc;
    logic [7:0] e8;

    #3 rst = 1'b1;
    #1;
    chk("rst_qa", qa, 8'h00);
    chk("rst_qb", qb, 8'hFF);
    chk("rst_idx", idxa, 0);
    chk("rst_active", acta, 0);
    chk("rst_wrap", wrapa, 0);
    chk_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_qa", qa, 8'h00);
      chk("idle_qb", qb, 8'hFF);
      chk("idle_active", acta, 0);
    end

    en = 1'b1; mode = 1'b0; i = 3'd2; load = 1'b1;
    @(negedge clk);
    load = 1'b0; i = 3'd7;
    chk("hold_q", qa, 8'h04);
    chk("hold_idx", idxa, 2);
    chk("hold_active", acta, 1);
    chk("hold_qb", qb, 8'hFB);
    @(negedge clk);
    chk("hold_noload_q", qa, 8'h04);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("hold_reload_q", qa, 8'h80);

    en = 1'b0;
    @(negedge clk);
    en = 1'b1; mode = 1'b1; i = 3'd6;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("scan_q", qa, (k <= 4) ? 8'h40 : (k <= 8) ? 8'h80 : 8'h01);
      chk("scan_wrap", wrapa, (k == 9) ? 1 : 0);
    end
    wc = 0;
    repeat (32) begin
      @(negedge clk);
      wc += int'(wrapa);
    end
    chk("sweep_wraps", wc, 1);

    en = 1'b0;
    @(negedge clk);
    en = 1'b1; mode = 1'b1; i = 3'd5;
    @(negedge clk);
    chk("int_idx5", idxa, 5);
    @(negedge clk);
    load = 1'b1; i = 3'd1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      load = 1'b0;
      chk("int_load_dwell", qa, 8'h02);
    end
    @(negedge clk);
    chk("int_step", qa, 8'h04);
    mode = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("int_freeze_q", qa, 8'h04);
      chk("int_freeze_idx", idxa, 2);
    end
    en = 1'b0;
    @(negedge clk);
    chk("int_off_q", qa, 8'h00);
    chk("int_off_active", acta, 0);

    en = 1'b1; mode = 1'b1; i = 3'd0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e8 = 8'h01 << ((k - 1) % 8);
      e8 = ~e8;
      chk("pol_q", qb, int'(e8));
      chk("pol_wrap", wrapb, (k == 9) ? 1 : 0);
    end
    wc = 0;
    repeat (16) begin
      @(negedge clk);
      wc += int'(wrapb);
    end
    chk("pol_wrap_count", wc, 2);

    repeat (3000) begin
      @(negedge clk);
      en   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      load = ($urandom_range(0, 4) == 0);
      i    = 3'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1;
        chk("midrst_qa", qa, 8'h00);
        chk("midrst_qb", qb, 8'hFF);
        chk("midrst_wrap", wrapb | wrapa, 0);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
